// File: rtl/id_ex_reg.sv
// ID/EX pipeline register: latches decoded operands/control for the execute stage,
// detects load-use hazards, inserts bubbles on hazard/flush, and counts hazard bubbles.
module id_ex_reg #(
    parameter int          DW          = 32,
    parameter logic [1:0]  WD_SEL_LOAD = 2'b01,
    parameter int          CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall_in,
    input  logic             flush,
    input  logic             id_valid,
    input  logic [DW-1:0]    id_pc,
    input  logic [DW-1:0]    id_pc4,
    input  logic [DW-1:0]    id_rD1,
    input  logic [DW-1:0]    id_rD2,
    input  logic [DW-1:0]    id_ext,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic [4:0]       id_rd,
    input  logic             id_re1,
    input  logic             id_re2,
    input  logic             id_alub_sel,
    input  logic [3:0]       id_alu_op,
    input  logic             id_rf_we,
    input  logic [1:0]       id_wd_sel,
    input  logic             id_ram_we,
    input  logic [2:0]       id_branch,
    input  logic             id_jump,
    output logic             ex_valid,
    output logic [DW-1:0]    ex_pc,
    output logic [DW-1:0]    ex_pc4,
    output logic [DW-1:0]    ex_rD1,
    output logic [DW-1:0]    ex_rD2,
    output logic [DW-1:0]    ex_ext,
    output logic [4:0]       ex_rs1,
    output logic [4:0]       ex_rs2,
    output logic [4:0]       ex_rd,
    output logic             ex_alub_sel,
    output logic [3:0]       ex_alu_op,
    output logic             ex_rf_we,
    output logic [1:0]       ex_wd_sel,
    output logic             ex_ram_we,
    output logic [2:0]       ex_branch,
    output logic             ex_jump,
    output logic             hazard_stall,
    output logic [CNT_W-1:0] bubble_cnt
);

    typedef struct packed {
        logic          valid;
        logic [DW-1:0] pc;
        logic [DW-1:0] pc4;
        logic [DW-1:0] rd1;
        logic [DW-1:0] rd2;
        logic [DW-1:0] ext;
        logic [4:0]    rs1;
        logic [4:0]    rs2;
        logic [4:0]    rd;
        logic          alub_sel;
        logic [3:0]    alu_op;
        logic          rf_we;
        logic [1:0]    wd_sel;
        logic          ram_we;
        logic [2:0]    branch;
        logic          jump;
    } ex_fields_t;

    ex_fields_t       fields_reg, fields_next, id_fields;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             ex_is_load;
    logic             ld_use;
    logic [4:0]       src_rs  [2];
    logic             src_re  [2];
    logic             src_hit [2];

    always_comb begin
        id_fields          = '0;
        id_fields.valid    = id_valid;
        id_fields.pc       = id_pc;
        id_fields.pc4      = id_pc4;
        id_fields.rd1      = id_rD1;
        id_fields.rd2      = id_rD2;
        id_fields.ext      = id_ext;
        id_fields.rs1      = id_rs1;
        id_fields.rs2      = id_rs2;
        id_fields.rd       = id_rd;
        id_fields.alub_sel = id_alub_sel;
        id_fields.alu_op   = id_alu_op;
        id_fields.rf_we    = id_rf_we;
        id_fields.wd_sel   = id_wd_sel;
        id_fields.ram_we   = id_ram_we;
        id_fields.branch   = id_branch;
        id_fields.jump     = id_jump;
    end

    // A load in EX writing a nonzero register that the decode instruction reads
    assign ex_is_load = fields_reg.valid & fields_reg.rf_we &
                        (fields_reg.wd_sel == WD_SEL_LOAD) & (fields_reg.rd != 5'd0);

    assign src_rs[0] = id_rs1;
    assign src_rs[1] = id_rs2;
    assign src_re[0] = id_re1;
    assign src_re[1] = id_re2;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_src
            assign src_hit[gi] = src_re[gi] & (src_rs[gi] == fields_reg.rd);
        end
    endgenerate

    assign ld_use       = ex_is_load & id_valid & (src_hit[0] | src_hit[1]);
    assign hazard_stall = ld_use & ~flush;

    // Flush beats stall so a resolved branch is never lost; a held register never counts
    always_comb begin
        fields_next = fields_reg;
        cnt_next    = cnt_reg;
        if (flush) begin
            fields_next = '0;
        end else if (stall_in) begin
            fields_next = fields_reg;
        end else if (ld_use) begin
            fields_next = '0;
            if (cnt_reg != {CNT_W{1'b1}}) begin
                cnt_next = cnt_reg + 1'b1;
            end
        end else begin
            fields_next = id_fields;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fields_reg <= '0;
            cnt_reg    <= '0;
        end else begin
            fields_reg <= fields_next;
            cnt_reg    <= cnt_next;
        end
    end

    assign ex_valid    = fields_reg.valid;
    assign ex_pc       = fields_reg.pc;
    assign ex_pc4      = fields_reg.pc4;
    assign ex_rD1      = fields_reg.rd1;
    assign ex_rD2      = fields_reg.rd2;
    assign ex_ext      = fields_reg.ext;
    assign ex_rs1      = fields_reg.rs1;
    assign ex_rs2      = fields_reg.rs2;
    assign ex_rd       = fields_reg.rd;
    assign ex_alub_sel = fields_reg.alub_sel;
    assign ex_alu_op   = fields_reg.alu_op;
    assign ex_rf_we    = fields_reg.rf_we;
    assign ex_wd_sel   = fields_reg.wd_sel;
    assign ex_ram_we   = fields_reg.ram_we;
    assign ex_branch   = fields_reg.branch;
    assign ex_jump     = fields_reg.jump;
    assign bubble_cnt  = cnt_reg;

endmodule

// File: tb/tb_id_ex_reg.sv
// Bench for id_ex_reg: directed scenarios then random traffic, checked against a
// priority-rule reference model of what EX should hold after each edge.
module tb_id_ex_reg;

    localparam int CNT_W   = 2;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] pc4;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] ext;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        alub_sel;
        logic [3:0]  alu_op;
        logic        rf_we;
        logic [1:0]  wd_sel;
        logic        ram_we;
        logic [2:0]  branch;
        logic        jump;
    } instr_t;

    logic clk = 1'b0;
    logic rst = 1'b0, stall_in = 1'b0, flush = 1'b0;
    logic id_re1 = 1'b0, id_re2 = 1'b0;
    instr_t id = '0;

    logic             ex_valid, ex_alub_sel, ex_rf_we, ex_ram_we, ex_jump, hazard_stall;
    logic [31:0]      ex_pc, ex_pc4, ex_rD1, ex_rD2, ex_ext;
    logic [4:0]       ex_rs1, ex_rs2, ex_rd;
    logic [3:0]       ex_alu_op;
    logic [1:0]       ex_wd_sel;
    logic [2:0]       ex_branch;
    logic [CNT_W-1:0] bubble_cnt;

    instr_t exp_ex = '0;
    int     exp_cnt = 0;
    bit     known = 0;
    int     n_cmp = 0, n_err = 0;

    always #5 clk = ~clk;

    id_ex_reg #(.DW(32), .WD_SEL_LOAD(2'b01), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .stall_in(stall_in), .flush(flush),
        .id_valid(id.valid), .id_pc(id.pc), .id_pc4(id.pc4),
        .id_rD1(id.rd1), .id_rD2(id.rd2), .id_ext(id.ext),
        .id_rs1(id.rs1), .id_rs2(id.rs2), .id_rd(id.rd),
        .id_re1(id_re1), .id_re2(id_re2),
        .id_alub_sel(id.alub_sel), .id_alu_op(id.alu_op), .id_rf_we(id.rf_we),
        .id_wd_sel(id.wd_sel), .id_ram_we(id.ram_we), .id_branch(id.branch), .id_jump(id.jump),
        .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_pc4(ex_pc4),
        .ex_rD1(ex_rD1), .ex_rD2(ex_rD2), .ex_ext(ex_ext),
        .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
        .ex_alub_sel(ex_alub_sel), .ex_alu_op(ex_alu_op), .ex_rf_we(ex_rf_we),
        .ex_wd_sel(ex_wd_sel), .ex_ram_we(ex_ram_we), .ex_branch(ex_branch), .ex_jump(ex_jump),
        .hazard_stall(hazard_stall), .bubble_cnt(bubble_cnt)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // The instruction in EX reads as a load whose result the decode instruction needs
    function automatic logic model_ld_use();
        logic reads_it;
        reads_it = (id_re1 && id.rs1 == exp_ex.rd) || (id_re2 && id.rs2 == exp_ex.rd);
        return exp_ex.valid && exp_ex.rf_we && exp_ex.wd_sel == 2'b01 && exp_ex.rd != 0
               && id.valid && reads_it;
    endfunction

    task automatic check_all(input string tag);
        check({tag, ":pc"},   64'(ex_pc),  64'(exp_ex.pc));
        check({tag, ":pc4"},  64'(ex_pc4), 64'(exp_ex.pc4));
        check({tag, ":rD1"},  64'(ex_rD1), 64'(exp_ex.rd1));
        check({tag, ":rD2"},  64'(ex_rD2), 64'(exp_ex.rd2));
        check({tag, ":ext"},  64'(ex_ext), 64'(exp_ex.ext));
        check({tag, ":regs"}, 64'({ex_rs1, ex_rs2, ex_rd}), 64'({exp_ex.rs1, exp_ex.rs2, exp_ex.rd}));
        check({tag, ":ctrl"},
              64'({ex_valid, ex_alub_sel, ex_alu_op, ex_rf_we, ex_wd_sel, ex_ram_we, ex_branch, ex_jump}),
              64'({exp_ex.valid, exp_ex.alub_sel, exp_ex.alu_op, exp_ex.rf_we, exp_ex.wd_sel,
                   exp_ex.ram_we, exp_ex.branch, exp_ex.jump}));
        check({tag, ":cnt"},  64'(bubble_cnt), 64'(exp_cnt));
    endtask

    // One clock: check hazard_stall before the edge, advance the model, check EX after it
    task automatic cycle(input string tag);
        logic   lu;
        instr_t nxt;
        int     ncnt;
        #1;
        lu = model_ld_use();
        if (known) check({tag, ":hz"}, 64'(hazard_stall), 64'(lu && !flush));
        nxt  = exp_ex;
        ncnt = exp_cnt;
        if (rst) begin
            nxt = '0; ncnt = 0;
        end else if (flush) begin
            nxt = '0;
        end else if (stall_in) begin
            nxt = exp_ex;
        end else if (lu) begin
            nxt = '0;
            ncnt = (exp_cnt < CNT_MAX) ? exp_cnt + 1 : CNT_MAX;
        end else begin
            nxt = id;
        end
        @(posedge clk);
        #1;
        if (known || rst) begin
            exp_ex = nxt; exp_cnt = ncnt; known = 1;
        end
        check_all(tag);
        $display("cycle %-12s rst=%0b flush=%0b stall=%0b lu=%0b ex_valid=%0b ex_pc=%h cnt=%0d",
                 tag, rst, flush, stall_in, lu, ex_valid, ex_pc, bubble_cnt);
    endtask

    function automatic instr_t mk_lw(input logic [4:0] rd, input logic [1:0] wd_sel);
        instr_t t = '0;
        t.valid = 1; t.pc = 32'h200; t.pc4 = 32'h204; t.rs1 = 5'd2; t.rd = rd;
        t.rf_we = 1; t.wd_sel = wd_sel; t.alub_sel = 1; t.ext = 32'h8;
        return t;
    endfunction

    function automatic instr_t mk_add(input logic [4:0] rs1);
        instr_t t = '0;
        t.valid = 1; t.pc = 32'h204; t.pc4 = 32'h208; t.rs1 = rs1; t.rs2 = 5'd1; t.rd = 5'd6;
        t.rf_we = 1; t.alu_op = 4'h1; t.rd1 = 32'h1111; t.rd2 = 32'h2222;
        return t;
    endfunction

    initial begin
        #20000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset with every id_* input driven high
        rst = 1; id = '1; id_re1 = 1; id_re2 = 1; stall_in = 1; flush = 1;
        cycle("reset");
        check("reset_valid_lit", 64'(ex_valid), 64'(0));
        check("reset_cnt_lit", 64'(bubble_cnt), 64'(0));
        rst = 0; stall_in = 0; flush = 0; id = '0; id_re1 = 0; id_re2 = 0;
        #1 check("reset_hz_lit", 64'(hazard_stall), 64'(0));

        // Pass-through
        id.pc = 32'h100; id.rd2 = 32'hDEADBEEF; id.ext = 32'h10; id.alub_sel = 1; id.valid = 1;
        cycle("pass");
        check("pass_rD2_lit", 64'(ex_rD2), 64'h0DEADBEEF);

        // Load-use: lw x5 then add x6,x5,x1
        id = mk_lw(5'd5, 2'b01); cycle("lw");
        id = mk_add(5'd5); id_re1 = 1; id_re2 = 1;
        #1 check("lu_hz_lit", 64'(hazard_stall), 64'(1));
        cycle("lu_bubble");
        check("lu_cnt_lit", 64'(bubble_cnt), 64'(1));
        cycle("lu_add");
        check("lu_rs1_lit", 64'(ex_rs1), 64'(5));

        // No-hazard variants: rd=0, re1=0, non-load wd_sel
        for (int v = 0; v < 3; v++) begin
            id = mk_lw((v == 0) ? 5'd0 : 5'd5, (v == 2) ? 2'b00 : 2'b01);
            id_re1 = 1; id_re2 = 1;
            cycle("nh_lw");
            id = mk_add(id.rd); id_re1 = (v != 1); id_re2 = 1;
            #1 check("nh_hz_lit", 64'(hazard_stall), 64'(0));
            cycle("nh_add");
        end

        // Flush alongside a load-use
        id = mk_lw(5'd5, 2'b01); id_re1 = 1; cycle("fl_lw");
        id = mk_add(5'd5); flush = 1;
        #1 check("fl_hz_lit", 64'(hazard_stall), 64'(0));
        cycle("fl_bubble");
        flush = 0;

        // Stall for 3 cycles while a load-use is pending, then reset mid-stall
        id = mk_lw(5'd7, 2'b01); cycle("st_lw");
        id = mk_add(5'd7); stall_in = 1;
        for (int i = 0; i < 3; i++) begin
            cycle("stall");
            id.pc = $urandom;
        end
        check("stall_rd_lit", 64'(ex_rd), 64'(7));
        rst = 1; cycle("st_rst");
        rst = 0;
        cycle("post_rst");
        stall_in = 0;

        // Five load-use bubbles saturate the 2-bit counter
        for (int i = 0; i < 5; i++) begin
            id = mk_lw(5'd9, 2'b01); id_re1 = 1; id_re2 = 0; cycle("sat_lw");
            id = mk_add(5'd9); cycle("sat_bub");
        end
        check("sat_cnt_lit", 64'(bubble_cnt), 64'(3));

        // Random traffic with small register indices to provoke hazards
        rst = 1; cycle("rnd_rst"); rst = 0;
        for (int i = 0; i < 400; i++) begin
            id.valid = $urandom_range(0, 3) != 0;
            id.pc = $urandom; id.pc4 = $urandom; id.rd1 = $urandom;
            id.rd2 = $urandom; id.ext = $urandom;
            id.rs1 = 5'($urandom_range(0, 3)); id.rs2 = 5'($urandom_range(0, 3));
            id.rd = 5'($urandom_range(0, 3));
            id.alub_sel = 1'($urandom); id.alu_op = 4'($urandom);
            id.rf_we = $urandom_range(0, 3) != 0; id.wd_sel = 2'($urandom);
            id.ram_we = 1'($urandom); id.branch = 3'($urandom); id.jump = 1'($urandom);
            id_re1 = 1'($urandom); id_re2 = 1'($urandom);
            flush = $urandom_range(0, 9) == 0;
            stall_in = $urandom_range(0, 6) == 0;
            rst = $urandom_range(0, 49) == 0;
            cycle("rnd");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
